uart_mmio: RTL
==============

# uart_mmio

Memory-mapped UART responder on the SimTop data-SRAM-style bus. Sits in SimTop beside `u_data_sram` and claims a small address window. Stores to the window are buffered in a TX FIFO and drained onto `io_uart_out_valid/ch` one character per pulse. Loads poll the simulator through `io_uart_in_valid/ch` and return received characters plus status.

## Interface
Parameters:
- `BASE_ADDR`, default 64'h0000_0000_1000_0000: window base; window is 16 bytes.
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, 2..64.
- `TX_GAP`, default 0: idle cycles forced between successive `io_uart_out_valid` pulses.
- `RX_POLL`, default 4: cycles between RX polls while the holding register is empty; ≥1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `en` in 1: bus access strobe.
- `we` in 8: byte write enables; nonzero means write.
- `addr` in 64: byte address.
- `wdata` in 64: write data.
- `rdata` out 64: read data, registered.
- `hit` out 1: combinational; `en` and addr inside the window.
- `io_uart_out_valid` out 1: one-cycle TX character strobe.
- `io_uart_out_ch` out 8: TX character, meaningful only while valid.
- `io_uart_in_valid` out 1: one-cycle RX poll request.
- `io_uart_in_ch` in 8: poll response, sampled in the same cycle as the request; 8'hff means no character.

## Operation
Address decode:
- offset = addr − BASE_ADDR, bits [3:3] only; addr[2:0] ignored.
- Accesses outside the window are ignored, and `rdata` is unchanged.

Offset 0x0, DATA:
- Write with `we[0]` set pushes `wdata[7:0]` into the TX FIFO. Writes with `we[0]` clear are ignored.
- Read returns {56'b0, rx_hold} when rx_valid is set, and clears rx_valid. Otherwise it returns {56'b0, 8'hff}.

Offset 0x8, STATUS, read-only:
- bit0: rx_valid.
- bit1: tx_full.
- bit2: tx_empty.
- bit3: tx_overflow, sticky.
- bits[14:8]: tx_count.
- All other bits are 0.
- A read clears tx_overflow. Writes are ignored.

TX path:
- Circular FIFO with read/write pointers of log2(FIFO_DEPTH) bits plus a count. Pointers wrap modulo FIFO_DEPTH.
- A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
- A rejected push drops the byte and sets tx_overflow.
- Drain FSM states:
  - IDLE → SEND when the FIFO is non-empty.
  - SEND, one cycle: pop the head and drive `io_uart_out_valid`=1 with ch=head.
  - SEND → GAP when TX_GAP > 0, loading gap_cnt=TX_GAP−1.
  - SEND → SEND when TX_GAP = 0 and the FIFO is still non-empty after the pop.
  - SEND → IDLE otherwise.
  - GAP counts gap_cnt down to 0, then → SEND if non-empty, else IDLE.

RX path:
- poll_cnt counts down from RX_POLL−1 while rx_valid=0.
- At 0, `io_uart_in_valid`=1 for that cycle.
- If `io_uart_in_ch` ≠ 8'hff: rx_hold ← ch and rx_valid ← 1.
- poll_cnt reloads after each poll.
- No polls are issued while rx_valid=1.
- A DATA read that clears rx_valid in the same cycle as a poll: the poll does not occur; poll_cnt reloads.

## Timing
- Reset values:
  - `rdata`=0, `io_uart_out_valid`=0, `io_uart_out_ch`=0, `io_uart_in_valid`=0.
  - FIFO empty; tx_overflow=0; rx_valid=0, rx_hold=0.
  - FSM IDLE; gap_cnt=0; poll_cnt=RX_POLL−1.
- Reset mid-operation discards FIFO contents and any pending RX character.
- `rdata` is valid the cycle after the `en` cycle (same as `sram`). STATUS reflects state before that cycle's updates.
- TX push in cycle N with an empty FIFO and FSM IDLE gives `io_uart_out_valid` in cycle N+2: FSM enters SEND at the N+1 edge, and the registered output shows in N+2.
- Back-to-back characters with TX_GAP=0: one per cycle.
- Character spacing with TX_GAP=g: g+1 cycles.
- `io_uart_in_valid` is registered; the `io_uart_in_ch` response is sampled in the same cycle it is high.

## Configuration
- `UART_MMIO_RX_EN` defined: the RX path is compiled as described.
- `UART_MMIO_RX_EN` undefined:
  - `io_uart_in_valid` is tied 0.
  - rx_valid is constant 0.
  - DATA reads return 64'h0000_0000_0000_00ff.
  - STATUS bit0 is 0.
  - The RX registers are not instantiated.

## Test plan
- Reset, then read STATUS → rdata=64'h0000_0000_0000_0004; `io_uart_out_valid` stays 0 for 20 cycles.
- Write 8'h41 to DATA at cycle N → `io_uart_out_valid`=1, ch=8'h41 at cycle N+2 only; STATUS read afterward = 0x0004.
- TX_GAP=2, write "ABC" on consecutive cycles → pulses at N+2, N+5, N+8 with ch 41, 42, 43.
- FIFO_DEPTH=8, 10 writes while the drain is held off by TX_GAP=15 → 8 accepted plus 1 popped slot. STATUS shows overflow bit3=1, and it clears after one STATUS read.
- `RX_POLL`=4, `io_uart_in_ch`=8'hff for 8 cycles then 8'h5a:
  - Polls every 4 cycles; the first poll seeing 8'h5a sets STATUS bit0.
  - DATA read → 0x5a; a second read → 0xff.
  - Polling resumes after the first read.
- Assert reset while the FIFO holds 5 bytes → no further `io_uart_out_valid`; STATUS=0x0004.

Source files
------------

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART responder on the data-SRAM-style bus.
// A 16-byte window at BASE_ADDR holds two registers:
//   0x0 DATA   - a store pushes a TX byte; a load returns the received byte or 8'hff
//   0x8 STATUS - {tx_count[14:8], tx_overflow, tx_empty, tx_full, rx_valid}
// TX bytes go through a circular FIFO and a drain FSM onto io_uart_out_*.
// Optional feature macro: UART_MMIO_RX_EN compiles the polled RX path.
// Without it, DATA loads return 8'hff and io_uart_in_valid is tied low.
module uart_mmio #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TX_GAP     = 0,
  parameter int          RX_POLL    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        hit,
  output logic        io_uart_out_valid,
  output logic [7:0]  io_uart_out_ch,
  output logic        io_uart_in_valid,
  input  logic [7:0]  io_uart_in_ch
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_RELOAD = GW'((TX_GAP > 0) ? (TX_GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } tx_state_e;

  // ---------------------------------------------------------------------------
  // Address decode. The unsigned subtraction wraps addresses below the base
  // to huge offsets, so a single upper-bits check covers both window edges.
  // ---------------------------------------------------------------------------
  logic [63:0] offset;
  logic        sel_status;
  logic        bus_wr;
  logic        bus_rd;
  logic        push_req;
  logic        status_rd;
  logic        unused_bits;

  assign offset     = addr - BASE_ADDR;
  assign hit        = en && (offset[63:4] == 60'd0);
  assign sel_status = offset[3];
  assign bus_wr     = hit && (we != 8'd0);
  assign bus_rd     = hit && (we == 8'd0);
  assign push_req   = bus_wr && !sel_status && we[0];
  assign status_rd  = bus_rd && sel_status;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_pop;
  logic          push_ok;

  // Pointer/count bookkeeping; a full FIFO still accepts a push when the drain pops.
  always_comb begin
    tx_full  = (count_q == DEPTH_C);
    tx_empty = (count_q == '0);
    push_ok  = push_req && (!tx_full || tx_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (tx_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, tx_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A dropped byte wins over the read-to-clear of the sticky flag.
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end else if (status_rd) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO storage: no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= wdata[7:0];
    end
  end

  // FIFO pointer, count and overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // TX drain FSM. The pop is decided on the transition into SEND so that the
  // registered strobe is high exactly during the SEND cycle; the count seen
  // while in SEND is therefore already the post-pop count.
  // ---------------------------------------------------------------------------
  tx_state_e     state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_ch_q, out_ch_d;

  // Next-state, pop decision and registered character output.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    tx_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          state_d = ST_SEND;
          tx_pop  = 1'b1;
        end
      end
      ST_SEND: begin
        if (TX_GAP > 0) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_RELOAD;
        end else if (!tx_empty) begin
          state_d = ST_SEND;
          tx_pop  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end else if (!tx_empty) begin
          state_d = ST_SEND;
          tx_pop  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = tx_pop;
    out_ch_d    = tx_pop ? fifo_mem[rd_ptr_q] : out_ch_q;
  end

  // FSM state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign io_uart_out_valid = out_valid_q;
  assign io_uart_out_ch    = out_ch_q;

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  logic        rx_valid;
  logic [63:0] data_word;

`ifdef UART_MMIO_RX_EN
  localparam int PW = (RX_POLL > 1) ? $clog2(RX_POLL) : 1;
  localparam logic [PW-1:0] POLL_RELOAD = PW'(RX_POLL - 1);

  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_hold_q, rx_hold_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic          in_valid_q, in_valid_d;
  logic          rx_capture;

  // Poll scheduling: the counter sits at its reload value while a character
  // is held (or being captured), so no poll is ever issued with rx_valid set,
  // and a DATA read that clears rx_valid restarts a full poll interval.
  always_comb begin
    rx_capture = in_valid_q && (io_uart_in_ch != 8'hff);
    rx_valid_d = rx_valid_q;
    rx_hold_d  = rx_hold_q;
    poll_cnt_d = poll_cnt_q;
    in_valid_d = 1'b0;
    if (rx_capture) begin
      rx_valid_d = 1'b1;
      rx_hold_d  = io_uart_in_ch;
    end else if (bus_rd && !sel_status && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end
    if (rx_valid_q || rx_capture) begin
      poll_cnt_d = POLL_RELOAD;
    end else if (poll_cnt_q == '0) begin
      in_valid_d = 1'b1;
      poll_cnt_d = POLL_RELOAD;
    end else begin
      poll_cnt_d = poll_cnt_q - 1'b1;
    end
  end

  // RX holding register, poll counter and registered poll strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_hold_q  <= 8'd0;
      poll_cnt_q <= POLL_RELOAD;
      in_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_hold_q  <= rx_hold_d;
      poll_cnt_q <= poll_cnt_d;
      in_valid_q <= in_valid_d;
    end
  end

  assign io_uart_in_valid = in_valid_q;
  assign rx_valid         = rx_valid_q;
  assign data_word        = rx_valid_q ? {56'd0, rx_hold_q} : 64'h0000_0000_0000_00ff;
  // Bus bits this responder does not decode.
  assign unused_bits      = ^{offset[2:0], wdata[63:8]};
`else
  assign io_uart_in_valid = 1'b0;
  assign rx_valid         = 1'b0;
  assign data_word        = 64'h0000_0000_0000_00ff;
  // Bus bits this responder does not decode, plus the idle RX input.
  assign unused_bits      = ^{offset[2:0], wdata[63:8], io_uart_in_ch};
`endif

  // ---------------------------------------------------------------------------
  // Read data. STATUS reports the state before this cycle's updates.
  // ---------------------------------------------------------------------------
  logic [63:0] status_word;
  logic [63:0] rdata_q, rdata_d;

  assign status_word = {49'd0, 7'(count_q), 4'd0, ovf_q, tx_empty, tx_full, rx_valid};

  // Load mux; accesses outside the window leave rdata untouched.
  always_comb begin
    rdata_d = rdata_q;
    if (bus_rd) begin
      rdata_d = sel_status ? status_word : data_word;
    end
  end

  // Registered read data, valid the cycle after the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 64'd0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
